// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory responder.
//   imem_stage_t  : one response-pipeline slot {v, addr, dat, err}
//   imem_state_e  : responder state (array clear, then normal service)
//   IMEM_MAX_LAT  : largest supported request-to-response latency
//   imem_in_range : word-index bounds test shared by the read and write paths
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_MAX_LAT = 4;

    typedef struct packed {
        logic        v;     // slot holds a live response
        logic [31:0] addr;  // word index the response belongs to
        logic [31:0] dat;   // instruction word (0 when err is set)
        logic        err;   // requested index was outside the array
    } imem_stage_t;

    typedef enum logic {
        IMEM_INIT,
        IMEM_RUN
    } imem_state_e;

    // True when a 32-bit word index addresses an existing array entry.
    function automatic logic imem_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/imem_lat_pipe.sv
// -----------------------------------------------------------------------------
// imem_lat_pipe
// LATENCY-deep shift register of imem_stage_t slots with stall and flush.
// The last slot is the response currently presented to the fetch stage.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, empties every slot
//   flush     in   drop every live slot at this edge (new entry still loads)
//   rsp_rdy   in   consumer takes the presented response
//   in_stage  in   slot entering stage 0 (v already qualified by acceptance)
//   out_stage out  last slot, drives the response outputs
//   stall     out  last slot is live and not taken; whole pipe holds
// -----------------------------------------------------------------------------
module imem_lat_pipe
    import imem_pkg::*;
#(
    parameter int LATENCY = 2   // 1 .. IMEM_MAX_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        rsp_rdy,
    input  imem_stage_t in_stage,
    output imem_stage_t out_stage,
    output logic        stall
);

    imem_stage_t stg [LATENCY];

    assign stall     = stg[LATENCY-1].v && !rsp_rdy;
    assign out_stage = stg[LATENCY-1];

    // NOTE: non-blocking assignments let every slot sample the previous slot's
    // pre-edge value, which is what makes this a shift rather than a ripple;
    // the later flush clear of the v bit overrides the earlier shift of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg[i] <= '0;
            end
        end else if (stall) begin
            // Held in place; a flush still kills the stalled responses.
            if (flush) begin
                for (int i = 0; i < LATENCY; i++) begin
                    stg[i].v <= 1'b0;
                end
            end
        end else begin
            stg[0] <= in_stage;
            for (int i = 1; i < LATENCY; i++) begin
                stg[i] <= stg[i-1];
            end
            // Stage 0 is exempt: a request accepted with the flush is the
            // jump target and must survive.
            if (flush) begin
                for (int i = 1; i < LATENCY; i++) begin
                    stg[i].v <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Memory end of the fetch request/response interface. Holds a DEPTH-word
// instruction array, clears it after every reset, then serves in-order reads
// with a fixed LATENCY and accepts preload writes.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_v      in   fetch presents a read request
//   req_addr   in   word index of the requested instruction
//   req_rdy    out  request accepted when req_v && req_rdy
//   flush      in   jump taken; drop every in-flight response
//   rsp_rdy    in   fetch takes the presented response
//   rsp_v      out  response valid
//   rsp_dat    out  instruction word
//   rsp_addr   out  word index the response belongs to
//   rsp_err    out  index was >= DEPTH (rsp_dat is 0)
//   wr_en      in   preload write strobe (ignored while clearing)
//   wr_addr    in   preload word index
//   wr_dat     in   preload data
//   init_done  out  array clear finished, responder serving requests
// -----------------------------------------------------------------------------
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = 512,  // power of two
    parameter int LATENCY = 2     // 1 .. IMEM_MAX_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_v,
    input  logic [31:0] req_addr,
    output logic        req_rdy,
    input  logic        flush,
    input  logic        rsp_rdy,
    output logic        rsp_v,
    output logic [31:0] rsp_dat,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_dat,
    output logic        init_done
);

    localparam int AW = $clog2(DEPTH);

    imem_state_e   state_q;
    imem_state_e   state_d;
    logic [AW-1:0] clr_cnt;
    logic          clr_last;
    logic          run;
    logic          stall;
    logic          accept;
    logic          req_in_range;
    logic          wr_in_range;
    logic          pipe_flush;
    imem_stage_t   in_stage;
    imem_stage_t   out_stage;

    logic [31:0]   mem [DEPTH];

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IMEM_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state. INIT lasts exactly DEPTH cycles, one word per cycle.
    // ---------------------------------------------------------------------
    assign clr_last = (clr_cnt == AW'(DEPTH - 1));

    // NOTE: every always_comb output gets a default before any branch so that
    // no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IMEM_INIT: if (clr_last) state_d = IMEM_RUN;
            IMEM_RUN:  state_d = IMEM_RUN;
            default:   state_d = IMEM_INIT;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        run       = (state_q == IMEM_RUN);
        init_done = run;
    end

    // ---------------------------------------------------------------------
    // Clear counter: walks 0 .. DEPTH-1 during INIT, wraps back to 0 on the
    // final clear write and then rests until the next reset.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (!run) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Word array: clear writes during INIT, preload writes during RUN.
    // Reads sample the pre-edge contents, so a same-cycle read and write to
    // one index return the old word.
    // ---------------------------------------------------------------------
    assign wr_in_range = imem_in_range(wr_addr, DEPTH);

    // NOTE: the array has no reset term; clearing is done word by word by the
    // INIT sequence, which keeps it mappable onto RAM primitives.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr[AW-1:0]] <= wr_dat;
        end
    end

    // ---------------------------------------------------------------------
    // Request acceptance and array read. The read happens here, at
    // acceptance; the pipe only adds delay.
    // ---------------------------------------------------------------------
    assign req_rdy      = run && !stall;
    assign accept       = req_v && req_rdy;
    assign req_in_range = imem_in_range(req_addr, DEPTH);
    assign pipe_flush   = flush && run;

    always_comb begin
        in_stage      = '0;
        in_stage.v    = accept;
        in_stage.addr = req_addr;
        in_stage.err  = !req_in_range;
        // Out-of-range indices never touch the array and return zero data.
        if (req_in_range) begin
            in_stage.dat = mem[req_addr[AW-1:0]];
        end
    end

    imem_lat_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (pipe_flush),
        .rsp_rdy   (rsp_rdy),
        .in_stage  (in_stage),
        .out_stage (out_stage),
        .stall     (stall)
    );

    assign rsp_v    = out_stage.v;
    assign rsp_dat  = out_stage.dat;
    assign rsp_addr = out_stage.addr;
    assign rsp_err  = out_stage.err;

endmodule
